// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder and its skew buffers.
package systolic_pkg;

  localparam int BITS_AB_DEFAULT = 8;
  localparam int DIM_DEFAULT     = 8;

  // Number of cycles needed to push a full DIM x DIM skewed wavefront through the array.
  function automatic int feed_len(input int dim);
    return 3 * dim - 2;
  endfunction

  localparam int FEED_LEN = feed_len(DIM_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DONE
  } feeder_state_t;

  typedef logic signed [DIM_DEFAULT-1:0][BITS_AB_DEFAULT-1:0] operand_vec_t;

endpackage

// File: rtl/skew_buffer.sv
// DIM x DIM operand register file with one lane write port and a registered,
// diagonally skewed, zero-padded output vector for the current feed step.
module skew_buffer
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT,
  parameter int STEP_W  = $clog2(feed_len(DIM))
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [$clog2(DIM)-1:0]            idx,
  input  logic signed [DIM-1:0][BITS_AB-1:0] data,
  input  logic                              fire,
  input  logic [STEP_W-1:0]                 step,
  output logic signed [DIM-1:0][BITS_AB-1:0] skewed
);

  localparam int IDX_W = $clog2(DIM);

  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem;
  logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] mem_next;
  logic [DIM-1:0][BITS_AB-1:0]          skew_next;

  // Apply this cycle's lane write so a same-cycle start sees the new operands.
  always_comb begin
    mem_next = mem;
    if (we) begin
      mem_next[idx] = data;
    end
  end

  // Lane i lags by i steps; anything outside its DIM-wide window is zero padding.
  always_comb begin
    int d;
    d         = 0;
    skew_next = '0;
    if (fire) begin
      for (int i = 0; i < DIM; i++) begin
        d = int'(step) - i;
        if (d >= 0 && d < DIM) begin
          skew_next[i] = mem_next[i][d[IDX_W-1:0]];
        end
      end
    end
  end

  // Register file contents and the registered skewed vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      skewed <= '0;
    end else begin
      mem    <= mem_next;
      skewed <= skew_next;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand staging and skew stage in front of the DIM x DIM systolic MAC array.
// Owns the feed FSM, the step counter and the A/B load decode.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic                              load_sel,
  input  logic [$clog2(DIM)-1:0]            load_idx,
  input  logic signed [DIM-1:0][BITS_AB-1:0] load_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              en_out,
  output logic signed [DIM-1:0][BITS_AB-1:0] A_out,
  output logic signed [DIM-1:0][BITS_AB-1:0] B_out
);

  localparam int              LEN    = feed_len(DIM);
  localparam int              STEP_W = $clog2(LEN);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(LEN - 1);

  feeder_state_t     state, state_next;
  logic [STEP_W-1:0] t, t_next;
  logic              we_a, we_b, fire;

  // Next-state and step sequencing; outputs are registered from the next-state view.
  always_comb begin
    state_next = state;
    t_next     = t;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FEED;
          t_next     = '0;
        end
      end
      FEED: begin
        if (t == LAST) begin
          state_next = DONE;
          t_next     = '0;
        end else begin
          t_next = t + STEP_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        t_next     = '0;
      end
    endcase
  end

  // Loads are only accepted while idle so buffers stay frozen for the whole feed.
  always_comb begin
    we_a = load && !load_sel && (state == IDLE);
    we_b = load &&  load_sel && (state == IDLE);
    fire = (state_next == FEED);
  end

  // FSM state, step counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      en_out <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      t      <= t_next;
      busy   <= fire;
      en_out <= fire;
      done   <= (state_next == DONE);
    end
  end

  skew_buffer #(
    .BITS_AB(BITS_AB),
    .DIM    (DIM),
    .STEP_W (STEP_W)
  ) u_buf_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we_a),
    .idx   (load_idx),
    .data  (load_data),
    .fire  (fire),
    .step  (t_next),
    .skewed(A_out)
  );

  skew_buffer #(
    .BITS_AB(BITS_AB),
    .DIM    (DIM),
    .STEP_W (STEP_W)
  ) u_buf_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we_b),
    .idx   (load_idx),
    .data  (load_data),
    .fire  (fire),
    .step  (t_next),
    .skewed(B_out)
  );

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand staging and skew stage that sits directly upstream of the DIM×DIM systolic MAC array. It buffers one DIM×DIM A matrix and one DIM×DIM B matrix, loaded one vector per cycle. On `start` it streams them into the array's A (row) and B (column) edge inputs with the diagonal skew the array requires, and drives the array's MAC enable for exactly the feed window. It then pulses `done` so the controller can read C rows back through the array's Crow/Cout port.

## Interface
- `BITS_AB`, default 8: signed operand width; must equal the array's `BITS_AB`.
- `DIM`, default 8: array dimension; must be ≥ 2.
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `load`  in  1  write `load_data` into a buffer lane this cycle; honoured only in IDLE.
- `load_sel`  in  1  0 = A buffer, 1 = B buffer.
- `load_idx`  in  $clog2(DIM)  lane index. For A it is the row r, with `load_data[k]` = A[r][k]. For B it is the column c, with `load_data[k]` = B[k][c].
- `load_data`  in  signed [BITS_AB-1:0] × DIM  vector written to the lane.
- `start`  in  1  begin a feed; honoured only in IDLE.
- `busy`  out  1  high in FEED.
- `done`  out  1  one-cycle pulse after the last feed cycle.
- `en_out`  out  1  array MAC enable; high exactly during feed cycles.
- `A_out`  out  signed [BITS_AB-1:0] × DIM  to array A inputs, lane = row.
- `B_out`  out  signed [BITS_AB-1:0] × DIM  to array B inputs, lane = column.

## Operation
- Buffers are two DIM×DIM arrays of BITS_AB registers, `bufA` and `bufB`, each indexed [lane][elem].
- Feed length is L = 3·DIM−2 cycles. The feed step t runs 0…L−1 and is held in a counter of width $clog2(L).
- During step t, for each lane i:
  - `A_out[i]` = `bufA[i][t−i]` if 0 ≤ t−i < DIM, else 0.
  - `B_out[i]` = `bufB[i][t−i]` under the same rule, else 0.
- Zero padding is mandatory because the array keeps accumulating while `en_out` is high.
- FSM states:
  - IDLE: `busy`=0, `en_out`=0, `A_out`/`B_out`=0. `load` writes its lane. `start` moves to FEED with t=0.
  - FEED: `busy`=1, `en_out`=1, t increments each cycle. When t = L−1, move to DONE.
  - DONE: single cycle with `done`=1, `en_out`=0, outputs 0. Then return to IDLE.
- In FEED and DONE, `load` and `start` are ignored; buffer contents are frozen.
- `load` and `start` asserted in the same IDLE cycle: the write lands and is visible to step t=0.
- Loading a lane twice in IDLE: the last write wins. Lanes never written since reset read as 0.
- Buffers persist across feeds, so a second `start` with no new loads replays the same operands.
- Arithmetic: pure data movement, no sign extension or truncation. Output width equals input width.

## Timing
- All outputs are registered.
- The cycle after the `start` sample: `en_out`=1, `busy`=1, and A_out/B_out carry step t=0.
- `en_out` stays high for exactly L consecutive cycles. `done` is high in the cycle immediately after.
- `start`-to-`done` latency is L+1 cycles. The earliest next `start` is the cycle after `done`.
- `load` writes take effect at the clock edge on which they are sampled.
- Reset values: `busy`=0, `done`=0, `en_out`=0, `A_out`=`B_out`=0, FSM in IDLE, t=0, all buffer entries 0.
- Reset mid-FEED: on the next edge the block is in IDLE with all outputs 0. No `done` is produced. The array sees `en_out` drop immediately.

## Structure
- Shared package `systolic_pkg`:
  - `BITS_AB`/`DIM` defaults.
  - `FEED_LEN` constant/function (3·DIM−2).
  - `feeder_state_t` enum {IDLE, FEED, DONE}.
  - Operand vector typedef.
- Sub-module `skew_buffer`, instanced twice (A and B):
  - Holds a DIM×DIM register file with one lane write port.
  - Produces the skewed, zero-padded output vector from t.
- The top level owns the FSM, step counter and `load_sel` decode.

## Test plan
- Reset, then idle: all outputs 0 for 10 cycles. `start` with no loads gives 22 cycles (DIM=8) of `en_out` with all-zero operands, then `done`.
- Load A = identity and B[k][c] = k·8+c. On `start`, check the lanes every cycle:
  - `A_out[i]`=1 only at t=2i.
  - `B_out[c]` at t equals (t−c)·8+c for 0 ≤ t−c < 8, else 0.
  - `done` rises 23 cycles after `start`.
- Signed extremes: A all −128, B all 127. Values reach the outputs unchanged; zero padding is observed at t=0 on lanes ≥1 and at t=21 on lanes ≤6.
- Abuse during FEED: `load` at t=5 and `start` at t=10. Outputs are unchanged versus the golden model, the feed is not restarted, and `done` timing is unchanged.
- `load` lane 3 and `start` in the same cycle: t=3 `A_out[3]` shows the new `load_data[0]`.
- `rst` at t=7: the next cycle `en_out`=0, `busy`=0, no `done`, all buffers read 0 on a subsequent feed.
